// File: rtl/mem_stage.sv
// Dual-issue MEM stage: registers the EX bus, restores program order,
// aligns/extends load data and holds it across stalls.
module mem_stage #(
  parameter int SLOT_WD     = 80,
  parameter int WB_SLOT_WD  = 70,
  parameter int FWD_SLOT_WD = 38,
  parameter int STALL_WD    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [STALL_WD-1:0]       stall,
  input  logic [2*SLOT_WD:0]        ex_to_mem_bus,
  input  logic [31:0]               data_sram_rdata,
  output logic [2*WB_SLOT_WD-1:0]   mem_to_wb_bus,
  output logic [2*FWD_SLOT_WD-1:0]  mem_to_rf_bus
);

  logic [2*SLOT_WD:0] r;
  logic               first_cyc;
  logic               hold_v;
  logic [31:0]        hold_d;

  logic mem_stop;
  logic wb_stop;
  logic bubble;

  assign mem_stop = stall[4];
  assign wb_stop  = stall[5];
  assign bubble   = mem_stop && !wb_stop;

  logic               sw;
  logic [SLOT_WD-1:0] slot_a;
  logic [SLOT_WD-1:0] slot_b;
  logic [SLOT_WD-1:0] older_s;
  logic [SLOT_WD-1:0] younger_s;

  assign sw     = r[2*SLOT_WD];
  assign slot_a = r[SLOT_WD-1:0];
  assign slot_b = r[2*SLOT_WD-1:SLOT_WD];

  // The pre-switch low slot is both the memory slot and the older one.
  assign older_s   = sw ? slot_b : slot_a;
  assign younger_s = sw ? slot_a : slot_b;

  logic [4:0] mem_lop;
  assign mem_lop = older_s[42:38];

  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      r         <= '0;
      first_cyc <= 1'b0;
      hold_v    <= 1'b0;
    end else if (!mem_stop) begin
      r         <= ex_to_mem_bus;
      first_cyc <= 1'b1;
      hold_v    <= 1'b0;
    end else begin
      first_cyc <= 1'b0;
      if (first_cyc && (mem_lop != 5'd0)) begin
        hold_v <= 1'b1;
        hold_d <= data_sram_rdata;
      end
    end
  end

  logic [31:0] rdata_eff;
  assign rdata_eff = first_cyc ? data_sram_rdata
                   : (hold_v ? hold_d : 32'd0);

  logic [1:0]  a;
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] old_wd;

  assign a       = older_s[1:0];
  assign shifted = rdata_eff >> {a, 3'b000};
  assign b       = shifted[7:0];
  assign h       = a[1] ? rdata_eff[31:16] : rdata_eff[15:0];

  always_comb begin
    old_wd = older_s[31:0];
    unique case (1'b1)
      mem_lop[0]: old_wd = {{24{b[7]}}, b};
      mem_lop[1]: old_wd = {24'd0, b};
      mem_lop[2]: old_wd = {{16{h[15]}}, h};
      mem_lop[3]: old_wd = {16'd0, h};
      mem_lop[4]: old_wd = rdata_eff;
      default:    old_wd = older_s[31:0];
    endcase
  end

  logic [WB_SLOT_WD-1:0]  old_wb;
  logic [WB_SLOT_WD-1:0]  yng_wb;
  logic [FWD_SLOT_WD-1:0] old_fwd;
  logic [FWD_SLOT_WD-1:0] yng_fwd;

  assign old_wb  = {older_s[79:48], older_s[37:32], old_wd};
  assign yng_wb  = {younger_s[79:48], younger_s[37:32], younger_s[31:0]};
  assign old_fwd = {older_s[37:32], old_wd};
  assign yng_fwd = {younger_s[37:32], younger_s[31:0]};

  assign mem_to_wb_bus = {yng_wb, old_wb};
  assign mem_to_rf_bus = {yng_fwd, old_fwd};

  logic unused_ok;
  assign unused_ok = ^{stall[3:0], older_s[47:43], younger_s[47:38]};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: ordering, load extension,
// stall hold, bubble and flush.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [5:0]   stall;
  logic [160:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [139:0] mem_to_wb_bus;
  logic [75:0]  mem_to_rf_bus;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] LB  = 5'b00001;
  localparam logic [4:0] LBU = 5'b00010;
  localparam logic [4:0] LH  = 5'b00100;
  localparam logic [4:0] LHU = 5'b01000;
  localparam logic [4:0] LW  = 5'b10000;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    string         tag;
    logic [139:0]  wb;
    logic [75:0]   rf;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag,
                       input logic [159:0] got,
                       input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] sl(
    input logic [31:0] pc, input logic en, input logic [3:0] wen,
    input logic [4:0] lop, input logic we, input logic [4:0] wa,
    input logic [31:0] res);
    return {pc, en, wen, lop, we, wa, res};
  endfunction

  function automatic logic [69:0] wbs(
    input logic [31:0] pc, input logic we,
    input logic [4:0] wa, input logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  function automatic logic [37:0] fw(
    input logic we, input logic [4:0] wa, input logic [31:0] wd);
    return {we, wa, wd};
  endfunction

  task automatic sb_push(input string tag,
                         input logic [139:0] wb,
                         input logic [75:0] rf);
    exp_t e;
    e.tag = tag;
    e.wb  = wb;
    e.rf  = rf;
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 160'd1, 160'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_wb"}, {20'd0, mem_to_wb_bus}, {20'd0, e.wb});
      check({e.tag, "_rf"}, {84'd0, mem_to_rf_bus}, {84'd0, e.rf});
    end
  endtask

  // Starts and ends 1ns after a posedge.
  task automatic run(input string tag, input logic [160:0] bus,
                     input logic [31:0] rd,
                     input logic [139:0] wb, input logic [75:0] rf);
    sb_push(tag, wb, rf);
    ex_to_mem_bus = bus;
    stall = 6'd0;
    @(posedge clk); #1;
    ex_to_mem_bus = '0;
    data_sram_rdata = rd;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;
  endtask

  task automatic run_ld(input string tag, input logic [4:0] op,
                        input logic [31:0] addr, input logic [31:0] rd,
                        input logic [31:0] exp_wd);
    run(tag, {1'b0, 80'd0, sl(32'h3000, 1'b1, 4'h0, op, 1'b1, 5'd8, addr)},
        rd, {70'd0, wbs(32'h3000, 1'b1, 5'd8, exp_wd)},
        {38'd0, fw(1'b1, 5'd8, exp_wd)});
  endtask

  logic [79:0] s_lw;
  logic [79:0] s_alu;
  logic [139:0] e_wb;
  logic [75:0]  e_rf;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    stall = 6'd0;
    ex_to_mem_bus = '0;
    data_sram_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wb", {20'd0, mem_to_wb_bus}, 160'd0);
    check("rst_rf", {84'd0, mem_to_rf_bus}, 160'd0);
    check("rst_hold_v", {159'd0, dut.hold_v}, 160'd0);
    @(posedge clk); #1;

    s_lw  = sl(32'h1000, 1'b1, 4'h0, LW, 1'b1, 5'd5, 32'h100);
    s_alu = sl(32'h1004, 1'b0, 4'h0, 5'd0, 1'b1, 5'd6, 32'h1234);
    e_wb = {wbs(32'h1004, 1'b1, 5'd6, 32'h1234),
            wbs(32'h1000, 1'b1, 5'd5, 32'hDEADBEEF)};
    e_rf = {fw(1'b1, 5'd6, 32'h1234), fw(1'b1, 5'd5, 32'hDEADBEEF)};
    run("sw0", {1'b0, s_alu, s_lw}, 32'hDEADBEEF, e_wb, e_rf);
    run("sw1", {1'b1, s_lw, s_alu}, 32'hDEADBEEF, e_wb, e_rf);

    run_ld("lb3",  LB,  32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    run_ld("lbu3", LBU, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    run_ld("lh2",  LH,  32'h102, 32'h80FF_0000, 32'hFFFF_80FF);
    run_ld("lhu2", LHU, 32'h102, 32'h80FF_0000, 32'h0000_80FF);
    run_ld("lb0",  LB,  32'h100, 32'h1234_567F, 32'h0000_007F);
    run_ld("lb1",  LB,  32'h101, 32'h0000_8100, 32'hFFFF_FF81);
    run_ld("lbu2", LBU, 32'h102, 32'h00AB_0000, 32'h0000_00AB);
    run_ld("lh0",  LH,  32'h100, 32'h0000_8001, 32'hFFFF_8001);
    run_ld("lw",   LW,  32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D);

    run("st", {1'b0, 80'd0,
               sl(32'h3100, 1'b1, 4'hF, 5'd0, 1'b0, 5'd0, 32'h200)},
        32'h5555_5555,
        {70'd0, wbs(32'h3100, 1'b0, 5'd0, 32'h200)},
        {38'd0, fw(1'b0, 5'd0, 32'h200)});

    // load held across a two-level stall
    e_wb = {70'd0, wbs(32'h2000, 1'b1, 5'd7, 32'hAAAA_0000)};
    e_rf = {38'd0, fw(1'b1, 5'd7, 32'hAAAA_0000)};
    for (int i = 0; i < 4; i++) sb_push($sformatf("hold%0d", i), e_wb, e_rf);
    ex_to_mem_bus = {1'b0, 80'd0,
                     sl(32'h2000, 1'b1, 4'h0, LW, 1'b1, 5'd7, 32'h300)};
    @(posedge clk); #1;
    ex_to_mem_bus = '0;
    stall = 6'b110000;
    data_sram_rdata = 32'hAAAA_0000;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;
    data_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    sb_pop();
    check("hold_v_set", {159'd0, dut.hold_v}, 160'd1);
    @(posedge clk); #1;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;
    stall = 6'd0;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;

    // bubble: MEM stops while WB runs
    s_alu = sl(32'h4000, 1'b0, 4'h0, 5'd0, 1'b1, 5'd9, 32'h0BAD_CAFE);
    sb_push("bub_pre", {70'd0, wbs(32'h4000, 1'b1, 5'd9, 32'h0BAD_CAFE)},
            {38'd0, fw(1'b1, 5'd9, 32'h0BAD_CAFE)});
    sb_push("bub", 140'd0, 76'd0);
    ex_to_mem_bus = {1'b0, 80'd0, s_alu};
    @(posedge clk); #1;
    stall = 6'b010000;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;
    stall = 6'd0;
    ex_to_mem_bus = '0;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;

    // flush beats a capture
    sb_push("fl_pre", {70'd0, wbs(32'h4000, 1'b1, 5'd9, 32'h0BAD_CAFE)},
            {38'd0, fw(1'b1, 5'd9, 32'h0BAD_CAFE)});
    sb_push("fl", 140'd0, 76'd0);
    ex_to_mem_bus = {1'b0, 80'd0, s_alu};
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;
    flush = 1'b0;
    ex_to_mem_bus = '0;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;

    // flush during a held load
    sb_push("flh_pre", {70'd0, wbs(32'h5000, 1'b1, 5'd3, 32'h1234_5678)},
            {38'd0, fw(1'b1, 5'd3, 32'h1234_5678)});
    sb_push("flh", 140'd0, 76'd0);
    ex_to_mem_bus = {1'b1, sl(32'h5000, 1'b1, 4'h0, LW, 1'b1, 5'd3, 32'h40),
                     80'd0};
    @(posedge clk); #1;
    ex_to_mem_bus = '0;
    stall = 6'b110000;
    data_sram_rdata = 32'h1234_5678;
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;
    data_sram_rdata = 32'h0;
    @(negedge clk);
    check("flh_hold_v_set", {159'd0, dut.hold_v}, 160'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    stall = 6'd0;
    @(negedge clk);
    sb_pop();
    check("flh_hold_v_clr", {159'd0, dut.hold_v}, 160'd0);
    check("sb_drained", {128'd0, 32'(sb.size())}, 160'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
